// File: rtl/int_regfile_mp.sv
// int_regfile_mp: multi-port integer register file with busy scoreboard.
//
// Holds NREGS = 2**ADDR_W registers of DATA_W bits. It has two combinational read
// ports, two write lanes with lane 1 taking priority on an address collision, an
// optional hardwired-zero register 0, optional same-cycle write-to-read forwarding,
// and a per-register busy bit that issue logic sets through the reserve port.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   rd_addr_a/b             read addresses
//   rd_data_a/b             read data (combinational)
//   rd_busy_a/b             busy bit of the read address (combinational)
//   wr0_en/addr/data        write lane 0
//   wr1_en/addr/data        write lane 1 (wins over lane 0 on the same address)
//   rsv_en, rsv_addr        reserve request: mark rsv_addr busy
//   rsv_ok                  rsv_addr can be reserved this cycle (combinational)
//   busy_cnt                number of busy registers (registered)
module int_regfile_mp #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  // Writes and reservations aimed at a hardwired-zero register are dropped here,
  // so nothing downstream needs to special-case address 0 for state updates.
  logic wr0_we, wr1_we, rsv_zero, rsv_set;

  assign wr0_we   = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_we   = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);

  // A register being written this cycle is reservable even if busy: the write
  // retires the old producer and the new reservation takes over.
  always_comb begin
    rsv_ok = !busy_q[rsv_addr] || (wr0_we && (wr0_addr == rsv_addr)) ||
             (wr1_we && (wr1_addr == rsv_addr));
    if (rsv_zero) begin
      rsv_ok = 1'b1;
    end
  end

  assign rsv_set = rsv_en && rsv_ok && !rsv_zero;

  // Next busy state and the resulting count delta; a set beats a clear.
  always_comb begin
    logic [ADDR_W:0] up, down;
    up   = '0;
    down = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_d[i] = busy_q[i];
      if ((wr0_we && (wr0_addr == ADDR_W'(i))) || (wr1_we && (wr1_addr == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end
      if (rsv_set && (rsv_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
      if (busy_d[i] && !busy_q[i]) begin
        up = up + 1'b1;
      end
      if (!busy_d[i] && busy_q[i]) begin
        down = down + 1'b1;
      end
    end
    busy_cnt_d = busy_cnt_q + up - down;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr0_we) begin
        regs_q[wr0_addr] <= wr0_data;
      end
      // Lane 1 assigned last so it wins a same-address collision.
      if (wr1_we) begin
        regs_q[wr1_addr] <= wr1_data;
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports: stored state, optionally overridden by forwarded write data.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BYPASS != 0) begin
        if (wr1_we && (wr1_addr == rd_addr[p])) begin
          rd_data[p] = wr1_data;
          rd_busy[p] = 1'b0;
        end else if (wr0_we && (wr0_addr == rd_addr[p])) begin
          rd_data[p] = wr0_data;
          rd_busy[p] = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_busy_a = rd_busy[0];
  assign rd_busy_b = rd_busy[1];

endmodule

// File: tb/tb_int_regfile_mp.sv
// tb_int_regfile_mp: directed self-checking bench for int_regfile_mp with default
// parameters (64-bit data, 32 registers, zero register and forwarding enabled).
module tb_int_regfile_mp;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              rd_busy_a, rd_busy_b;
  logic              wr0_en, wr1_en, rsv_en, rsv_ok;
  logic [ADDR_W-1:0] wr0_addr, wr1_addr, rsv_addr;
  logic [DATA_W-1:0] wr0_data, wr1_data;
  logic [ADDR_W:0]   busy_cnt;

  int total = 0;
  int bad   = 0;

  int_regfile_mp #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a),
    .rd_busy_b(rd_busy_b),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    wr0_en   = 1'b0;
    wr0_addr = '0;
    wr0_data = '0;
    wr1_en   = 1'b0;
    wr1_addr = '0;
    wr1_data = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd31;
    reset = 1'b0;
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", busy_cnt);
    end
    total++;
    if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0/0", rd_data_a, rd_data_b);
    end
    total++;
    if (rd_busy_a !== 1'b0 || rsv_ok !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy got busy=%b ok=%b want 0/1", rd_busy_a, rsv_ok);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_collision();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 64'h22;
    rd_addr_a = 5'd5;
    #1;
    total++;
    if (rd_data_a !== 64'h22) begin
      bad++;
      $display("FAIL collide_bypass got=%h want=22", rd_data_a);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_data_a !== 64'h22) begin
      bad++;
      $display("FAIL collide_stored got=%h want=22", rd_data_a);
    end
    // Different addresses: both lanes land, lane 0 forwarded on port B.
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 64'h66;
    wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 64'h88;
    rd_addr_a = 5'd8;
    rd_addr_b = 5'd6;
    #1;
    total++;
    if (rd_data_a !== 64'h88 || rd_data_b !== 64'h66) begin
      bad++;
      $display("FAIL dual_bypass got=%h/%h want=88/66", rd_data_a, rd_data_b);
    end
    tick();
    idle();
    rd_addr_a = 5'd5;
    #1;
    total++;
    if (rd_data_a !== 64'h22 || rd_data_b !== 64'h66) begin
      bad++;
      $display("FAIL dual_stored got=%h/%h want=22/66", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr_a = 5'd0;
    #1;
    total++;
    if (rd_data_a !== 64'd0 || rsv_ok !== 1'b1) begin
      bad++;
      $display("FAIL zero_comb got data=%h ok=%b want 0/1", rd_data_a, rsv_ok);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_data_a !== 64'd0 || rd_busy_a !== 1'b0 || busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL zero_after got data=%h busy=%b cnt=%0d want 0/0/0",
               rd_data_a, rd_busy_a, busy_cnt);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    rd_addr_a = 5'd7;
    #1;
    total++;
    if (rsv_ok !== 1'b1) begin
      bad++;
      $display("FAIL sb_ok_free got=%b want=1", rsv_ok);
    end
    tick();
    #1;
    total++;
    if (rd_busy_a !== 1'b1 || busy_cnt !== 6'd1 || rsv_ok !== 1'b0) begin
      bad++;
      $display("FAIL sb_reserved got busy=%b cnt=%0d ok=%b want 1/1/0",
               rd_busy_a, busy_cnt, rsv_ok);
    end
    tick();
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd1 || rd_busy_a !== 1'b1) begin
      bad++;
      $display("FAIL sb_rereserve got cnt=%0d busy=%b want 1/1", busy_cnt, rd_busy_a);
    end
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'hABCD;
    #1;
    total++;
    if (rd_busy_a !== 1'b0 || rd_data_a !== 64'hABCD) begin
      bad++;
      $display("FAIL sb_bypass got busy=%b data=%h want 0/abcd", rd_busy_a, rd_data_a);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_busy_a !== 1'b0 || busy_cnt !== 6'd0 || rd_data_a !== 64'hABCD) begin
      bad++;
      $display("FAIL sb_written got busy=%b cnt=%0d data=%h want 0/0/abcd",
               rd_busy_a, busy_cnt, rd_data_a);
    end
    // Write to a register that was never reserved: data lands, count untouched.
    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 64'h1212;
    tick();
    idle();
    rd_addr_b = 5'd12;
    #1;
    total++;
    if (rd_data_b !== 64'h1212 || rd_busy_b !== 1'b0 || busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL sb_nonbusy got data=%h busy=%b cnt=%0d want 1212/0/0",
               rd_data_b, rd_busy_b, busy_cnt);
    end
  endtask

  task automatic test_write_reserve();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h9999;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr_a = 5'd9;
    #1;
    total++;
    if (rsv_ok !== 1'b1 || busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL wrrsv_ok got ok=%b cnt=%0d want 1/1", rsv_ok, busy_cnt);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_data_a !== 64'h9999 || rd_busy_a !== 1'b1 || busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL wrrsv_after got data=%h busy=%b cnt=%0d want 9999/1/1",
               rd_data_a, rd_busy_a, busy_cnt);
    end
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h9;
    tick();
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd0 || rd_data_a !== 64'h9) begin
      bad++;
      $display("FAIL wrrsv_clear got cnt=%0d data=%h want 0/9", busy_cnt, rd_data_a);
    end
  endtask

  task automatic test_fill();
    int exp_cnt;
    for (int i = 1; i < 32; i++) begin
      idle();
      rsv_en = 1'b1; rsv_addr = ADDR_W'(i);
      tick();
    end
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd31) begin
      bad++;
      $display("FAIL fill_peak got=%0d want=31", busy_cnt);
    end
    exp_cnt = 31;
    for (int i = 1; i < 32; i += 2) begin
      idle();
      wr0_en = 1'b1; wr0_addr = ADDR_W'(i); wr0_data = 64'h1000 + 64'(i);
      exp_cnt--;
      if (i < 31) begin
        wr1_en = 1'b1; wr1_addr = ADDR_W'(i + 1); wr1_data = 64'h1000 + 64'(i + 1);
        exp_cnt--;
      end
      tick();
      idle();
      #1;
      total++;
      if (busy_cnt !== 6'(exp_cnt)) begin
        bad++;
        $display("FAIL fill_drain step=%0d got=%0d want=%0d", i, busy_cnt, exp_cnt);
      end
    end
    rd_addr_a = 5'd31;
    rd_addr_b = 5'd16;
    #1;
    total++;
    if (rd_data_a !== 64'h101F || rd_data_b !== 64'h1010 || rd_busy_a !== 1'b0) begin
      bad++;
      $display("FAIL fill_data got=%h/%h busy=%b want 101f/1010/0",
               rd_data_a, rd_data_b, rd_busy_a);
    end
  endtask

  task automatic test_async_reset();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle();
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd16;
    #3;
    // Pending write and reservation held across an edge while in reset.
    wr0_en = 1'b1; wr0_addr = 5'd16; wr0_data = 64'h5A5A;
    rsv_en = 1'b1; rsv_addr = 5'd20;
    reset = 1'b0;
    #1;
    total++;
    if (busy_cnt !== 6'd0 || rd_busy_a !== 1'b0 || rd_data_a !== 64'd0) begin
      bad++;
      $display("FAIL async_reset got cnt=%0d busy=%b data=%h want 0/0/0",
               busy_cnt, rd_busy_a, rd_data_a);
    end
    tick();
    #2;
    idle();
    reset = 1'b1;
    rd_addr_a = 5'd20;
    #1;
    total++;
    if (rd_data_b !== 64'd0 || rd_busy_a !== 1'b0 || busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_discard got data=%h busy=%b cnt=%0d want 0/0/0",
               rd_data_b, rd_busy_a, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_write_reserve();
    test_fill();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
